abl_seq: RTL and testbench

ABL_SEQ -- requirements
Module: abl_seq

---
 rtl/abl_seq_pkg.sv | 92 +++++++++
 rtl/abl_seq_dec.sv | 59 +++++
 rtl/abl_seq.sv | 160 ++++++++++++++++
 tb/tb_abl_seq.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/abl_seq_pkg.sv
// -----------------------------------------------------------------------------
// abl_seq_pkg -- shared definitions for the ABL address-sequencing controller.
//
// Holds the ABL operation encodings, the addressing-mode and FSM-state
// enumerations, the high-byte fix-up codes, the packed control bundle passed
// from the decoder to the top, and two helpers that capture the per-mode
// sequencing rules (first step, page-crossing fix-up).
//
// Optional feature macro (consumed by abl_seq): ABL_SEQ_PAGEFIX_EN
// -----------------------------------------------------------------------------
package abl_seq_pkg;

   // ABL adder operation encodings
   localparam logic [3:0] OP_PCL0   = 4'b0000;
   localparam logic [3:0] OP_REG0   = 4'b0101;
   localparam logic [3:0] OP_ABLDB  = 4'b1010;
   localparam logic [3:0] OP_ABL0   = 4'b1001;
   localparam logic [3:0] OP_REGDB  = 4'b0110;
   localparam logic [3:0] OP_REGAHL = 4'b0111;

   // High-byte fix-up codes (2'b10 is unused)
   typedef enum logic [1:0] {
      ABH_NONE = 2'b00,
      ABH_INC  = 2'b01,
      ABH_DEC  = 2'b11
   } abh_e;

   // Addressing sequence codes; code 7 is an alias of NEXT
   typedef enum logic [2:0] {
      MD_NEXT     = 3'd0,
      MD_ZPIDX    = 3'd1,
      MD_ABSIDX   = 3'd2,
      MD_BRANCH   = 3'd3,
      MD_STACK    = 3'd4,
      MD_VECTOR   = 3'd5,
      MD_RESTORE  = 3'd6,
      MD_NEXT_ALT = 3'd7
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH1 = 3'd1,
      ST_FETCH2 = 3'd2,
      ST_EA     = 3'd3,
      ST_EA2    = 3'd4,
      ST_FIX    = 3'd5
   } state_e;

   // Control bundle driven onto the ABL datapath every cycle
   typedef struct packed {
      logic [3:0] op;
      logic       ci;
      logic       ld_ahl;
      logic       ld_pc;
      logic       inc_pc;
      abh_e       abh_adj;
   } ctl_t;

   // "Hold": add zero with no carry, nothing loaded, no high-byte change
   localparam ctl_t CTL_HOLD = '{
      op:      OP_ABL0,
      ci:      1'b0,
      ld_ahl:  1'b0,
      ld_pc:   1'b0,
      inc_pc:  1'b0,
      abh_adj: ABH_NONE
   };

   // Modes that read an operand byte through PC start in FETCH1; the rest
   // go straight to the effective-address step.
   function automatic state_e first_step(input mode_e m);
      case (m)
         MD_ZPIDX, MD_ABSIDX, MD_BRANCH: first_step = ST_FETCH1;
         default:                        first_step = ST_EA;
      endcase
   endfunction

   // High-byte correction needed after the EA add. Indexed absolute can only
   // carry upward; a branch crosses a page whenever the carry disagrees with
   // the offset sign, downward when there was no carry. Zero-page indexing
   // deliberately wraps, so it never asks for a fix.
   function automatic abh_e page_fix(input mode_e m, input logic co,
                                     input logic db_sign);
      page_fix = ABH_NONE;
      case (m)
         MD_ABSIDX: if (co) page_fix = ABH_INC;
         MD_BRANCH: if (co != db_sign) page_fix = co ? ABH_INC : ABH_DEC;
         default:   page_fix = ABH_NONE;
      endcase
   endfunction

endpackage : abl_seq_pkg

// File: rtl/abl_seq_dec.sv
// -----------------------------------------------------------------------------
// abl_seq_dec -- combinational control decode for abl_seq.
//
// Maps (current state, latched mode, registered fix-up code) to the ABL
// control bundle. A stall forces the hold bundle so the datapath does not
// move while the CPU is not ready.
//
// Ports:
//   state_i    in  state_e  current sequencer state
//   mode_i     in  mode_e   mode latched when the sequence started
//   fix_adj_i  in  abh_e    high-byte fix code captured at the end of EA
//   stall_i    in  1        CPU not ready; force hold
//   ctl_o      out ctl_t    op / ci / load controls / abh_adj
// -----------------------------------------------------------------------------
module abl_seq_dec
   import abl_seq_pkg::*;
(
   input  state_e state_i,
   input  mode_e  mode_i,
   input  abh_e   fix_adj_i,
   input  logic   stall_i,
   output ctl_t   ctl_o
);

   always_comb begin
      // NOTE: assign a default before any branch so every path drives ctl_o
      // and no latch is inferred.
      ctl_o = CTL_HOLD;
      if (!stall_i) begin
         case (state_i)
            ST_FETCH1: begin
               ctl_o.ci     = 1'b1;
               ctl_o.ld_pc  = 1'b1;
               ctl_o.inc_pc = 1'b1;
            end
            ST_FETCH2: begin
               ctl_o.ci     = 1'b1;
               ctl_o.ld_ahl = 1'b1;
               ctl_o.ld_pc  = 1'b1;
               ctl_o.inc_pc = 1'b1;
            end
            ST_EA: begin
               case (mode_i)
                  MD_ZPIDX:            ctl_o.op = OP_REGDB;
                  MD_ABSIDX:           ctl_o.op = OP_REGAHL;
                  MD_BRANCH:           ctl_o.op = OP_ABLDB;
                  MD_STACK, MD_VECTOR: ctl_o.op = OP_REG0;
                  MD_RESTORE:          ctl_o.op = OP_PCL0;
                  default:             ctl_o.ci = 1'b1;  // NEXT and its alias
               endcase
            end
            ST_EA2:  ctl_o.ci      = 1'b1;
            ST_FIX:  ctl_o.abh_adj = fix_adj_i;
            default: ctl_o = CTL_HOLD;
         endcase
      end
   end

endmodule : abl_seq_dec

// File: rtl/abl_seq.sv
// -----------------------------------------------------------------------------
// abl_seq -- ABL address-sequencing controller (top).
//
// Accepts a start request in IDLE, latches the addressing mode and steps
// through FETCH1 / FETCH2 / EA / EA2 / FIX as the mode requires, driving the
// ABL adder controls each cycle. A one-cycle done pulse follows the final
// step; the next sequence may start in that same cycle. rdy=0 freezes the
// sequencer and forces hold controls.
//
// Optional feature: define ABL_SEQ_PAGEFIX_EN to include the FIX step that
// corrects the address high byte after a page crossing. Without it ABSIDX and
// BRANCH end after EA (page wrap) and abh_adj is tied to 00.
//
// Ports:
//   clk      in  1  system clock, rising edge
//   rst_n    in  1  asynchronous active-low reset
//   start    in  1  request a sequence
//   mode     in  3  addressing sequence code
//   rdy      in  1  CPU ready, 0 = stall
//   co       in  1  ABL adder carry-out (sampled in EA)
//   db_sign  in  1  DB[7], branch offset sign (sampled in EA)
//   op       out 4  ABL operation
//   ci       out 1  ABL carry-in
//   ld_ahl   out 1  load address-high latch
//   ld_pc    out 1  load PC
//   inc_pc   out 1  increment PC
//   abh_adj  out 2  high-byte fix: 00 none, 01 increment, 11 decrement
//   busy     out 1  sequence active
//   done     out 1  one-cycle completion pulse
// -----------------------------------------------------------------------------
module abl_seq
   import abl_seq_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [2:0] mode,
   input  logic       rdy,
   input  logic       co,
   input  logic       db_sign,
   output logic [3:0] op,
   output logic       ci,
   output logic       ld_ahl,
   output logic       ld_pc,
   output logic       inc_pc,
   output logic [1:0] abh_adj,
   output logic       busy,
   output logic       done
);

   state_e state_q, state_d;
   mode_e  mode_q,  mode_d;
   logic   done_q,  done_d;
   abh_e   fix_q;
   ctl_t   ctl;

`ifdef ABL_SEQ_PAGEFIX_EN
   abh_e fix_d;
   abh_e ea_fix;

   assign ea_fix = page_fix(mode_q, co, db_sign);
`else
   // Page-crossing inputs and the decoded fix code have no consumer when the
   // fix-up step is compiled out.
   logic [3:0] unused_nofix;

   assign fix_q        = ABH_NONE;
   assign unused_nofix = {co, db_sign, ctl.abh_adj};
`endif

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         mode_q  <= MD_NEXT;
         done_q  <= 1'b0;
      end else begin
         // NOTE: clocked state uses non-blocking assignments so every register
         // samples the pre-edge values regardless of statement order.
         state_q <= state_d;
         mode_q  <= mode_d;
         done_q  <= done_d;
      end
   end

`ifdef ABL_SEQ_PAGEFIX_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fix_q <= ABH_NONE;
      else        fix_q <= fix_d;
   end
`endif

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      done_d  = done_q;   // a pending done waits out a stall
`ifdef ABL_SEQ_PAGEFIX_EN
      fix_d   = fix_q;
`endif
      if (rdy) begin
         done_d = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  mode_d  = mode_e'(mode);
                  state_d = first_step(mode_e'(mode));
               end
            end
            ST_FETCH1: state_d = (mode_q == MD_ABSIDX) ? ST_FETCH2 : ST_EA;
            ST_FETCH2: state_d = ST_EA;
            ST_EA: begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               if (mode_q == MD_VECTOR) begin
                  state_d = ST_EA2;
                  done_d  = 1'b0;
               end
`ifdef ABL_SEQ_PAGEFIX_EN
               // Carry and sign are only meaningful during EA; the decision
               // is registered here and replayed in FIX.
               fix_d = ea_fix;
               if (ea_fix != ABH_NONE) begin
                  state_d = ST_FIX;
                  done_d  = 1'b0;
               end
`endif
            end
            ST_EA2, ST_FIX: begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------ outputs
   abl_seq_dec u_dec (
      .state_i   (state_q),
      .mode_i    (mode_q),
      .fix_adj_i (fix_q),
      .stall_i   (~rdy),
      .ctl_o     (ctl)
   );

   assign op     = ctl.op;
   assign ci     = ctl.ci;
   assign ld_ahl = ctl.ld_ahl;
   assign ld_pc  = ctl.ld_pc;
   assign inc_pc = ctl.inc_pc;
`ifdef ABL_SEQ_PAGEFIX_EN
   assign abh_adj = ctl.abh_adj;
`else
   assign abh_adj = 2'b00;
`endif
   assign busy   = (state_q != ST_IDLE);
   assign done   = done_q & rdy;

endmodule : abl_seq

// File: tb/tb_abl_seq.sv
// -----------------------------------------------------------------------------
// tb_abl_seq -- self-checking bench for abl_seq.
//
// Directed sequences push their expected per-cycle output vectors into a
// scoreboard queue; a monitor on the falling clock edge pops one entry for
// every cycle in which the DUT reports busy or done. Expected vectors pack
// {op, ci, ld_ahl, ld_pc, inc_pc, abh_adj, busy, done}. Expectations for the
// fix-up step follow ABL_SEQ_PAGEFIX_EN.
// -----------------------------------------------------------------------------
module tb_abl_seq;

   logic       clk = 1'b0;
   logic       rst_n, start, rdy, co, db_sign;
   logic [2:0] mode;
   logic [3:0] op;
   logic       ci, ld_ahl, ld_pc, inc_pc, busy, done;
   logic [1:0] abh_adj;
   logic [11:0] dut_vec;

   always #5 clk = ~clk;

   abl_seq dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .mode    (mode),
      .rdy     (rdy),
      .co      (co),
      .db_sign (db_sign),
      .op      (op),
      .ci      (ci),
      .ld_ahl  (ld_ahl),
      .ld_pc   (ld_pc),
      .inc_pc  (inc_pc),
      .abh_adj (abh_adj),
      .busy    (busy),
      .done    (done)
   );

   assign dut_vec = {op, ci, ld_ahl, ld_pc, inc_pc, abh_adj, busy, done};

   typedef struct {
      logic [11:0] vec;
      string       tag;
   } exp_t;

   exp_t sb_q[$];
   int   compared   = 0;
   int   mismatched = 0;

   function automatic logic [11:0] ev(input logic [3:0] o, input logic c,
                                      input logic a, input logic p,
                                      input logic i, input logic [1:0] adj,
                                      input logic b, input logic d);
      return {o, c, a, p, i, adj, b, d};
   endfunction

   // Hand-derived vectors
   localparam logic [11:0] V_IDLE   = {4'b1001, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0};
   localparam logic [11:0] V_HOLD_B = {4'b1001, 1'b0, 3'b000, 2'b00, 1'b1, 1'b0};
   localparam logic [11:0] V_DONE   = {4'b1001, 1'b0, 3'b000, 2'b00, 1'b0, 1'b1};
   localparam logic [11:0] V_F1     = {4'b1001, 1'b1, 3'b011, 2'b00, 1'b1, 1'b0};
   localparam logic [11:0] V_F2     = {4'b1001, 1'b1, 3'b111, 2'b00, 1'b1, 1'b0};
   localparam logic [11:0] V_EA_NX  = {4'b1001, 1'b1, 3'b000, 2'b00, 1'b1, 1'b0};
   localparam logic [11:0] V_EA_ZP  = {4'b0110, 1'b0, 3'b000, 2'b00, 1'b1, 1'b0};
   localparam logic [11:0] V_EA_ABS = {4'b0111, 1'b0, 3'b000, 2'b00, 1'b1, 1'b0};
   localparam logic [11:0] V_EA_BR  = {4'b1010, 1'b0, 3'b000, 2'b00, 1'b1, 1'b0};
   localparam logic [11:0] V_EA_R0  = {4'b0101, 1'b0, 3'b000, 2'b00, 1'b1, 1'b0};
   localparam logic [11:0] V_EA_PC  = {4'b0000, 1'b0, 3'b000, 2'b00, 1'b1, 1'b0};
   localparam logic [11:0] V_EA2    = {4'b1001, 1'b1, 3'b000, 2'b00, 1'b1, 1'b0};
   localparam logic [11:0] V_FIX_UP = {4'b1001, 1'b0, 3'b000, 2'b01, 1'b1, 1'b0};
   localparam logic [11:0] V_FIX_DN = {4'b1001, 1'b0, 3'b000, 2'b11, 1'b1, 1'b0};

`ifdef ABL_SEQ_PAGEFIX_EN
   localparam int PF = 1;
`else
   localparam int PF = 0;
`endif

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic push(input string tag, input logic [11:0] v);
      exp_t e;
      e.vec = v;
      e.tag = tag;
      sb_q.push_back(e);
   endtask

   // Drive start for one edge; mode is scrambled afterwards so the DUT must
   // rely on its latched copy.
   task automatic issue(input logic [2:0] m);
      start = 1'b1;
      mode  = m;
      @(posedge clk);
      #1;
      start = 1'b0;
      mode  = ~m;
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(input string tag);
      check({"drain_", tag}, 32'(sb_q.size()), 32'd0);
      sb_q.delete();
   endtask

   // ---------------------------------------------------------------- monitor
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && (busy || done)) begin
         if (sb_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_output: got %h, expected no activity",
                     dut_vec);
         end else begin
            e = sb_q.pop_front();
            check(e.tag, 32'(dut_vec), 32'(e.vec));
         end
      end
   end

   // --------------------------------------------------------------- watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, expected summary first");
      $fatal(1, "watchdog expired");
   end

   // --------------------------------------------------------------- stimulus
   initial begin
      rst_n   = 1'b0;
      start   = 1'b1;   // held through reset: first edge after release takes it
      mode    = 3'd0;
      rdy     = 1'b1;
      co      = 1'b0;
      db_sign = 1'b0;
      #2;
      check("reset_outputs", 32'(dut_vec), 32'(V_IDLE));

      // NEXT straight out of reset: EA then done
      push("next_ea", V_EA_NX);
      push("next_done", V_DONE);
      #10;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      mode  = 3'd7;
      cycles(2);
      drain("next");

      // ABSIDX with carry: FIX increment when enabled
      co = 1'b1;
      push("abs_f1", V_F1);
      push("abs_f2", V_F2);
      push("abs_ea", V_EA_ABS);
      if (PF == 1) push("abs_fix_inc", V_FIX_UP);
      push("abs_done", V_DONE);
      issue(3'd2);
      cycles(4 + PF);
      drain("abs_co1");

      // BRANCH backward, no carry: FIX decrement when enabled
      co = 1'b0; db_sign = 1'b1;
      push("br_f1", V_F1);
      push("br_ea", V_EA_BR);
      if (PF == 1) push("br_fix_dec", V_FIX_DN);
      push("br_done", V_DONE);
      issue(3'd3);
      cycles(3 + PF);
      drain("br_s1_c0");

      // BRANCH backward with carry: same page, done at cycle 3
      co = 1'b1; db_sign = 1'b1;
      push("br2_f1", V_F1);
      push("br2_ea", V_EA_BR);
      push("br2_done", V_DONE);
      issue(3'd3);
      cycles(3);
      drain("br_s1_c1");

      // BRANCH forward with carry: FIX increment when enabled
      co = 1'b1; db_sign = 1'b0;
      push("br3_f1", V_F1);
      push("br3_ea", V_EA_BR);
      if (PF == 1) push("br3_fix_inc", V_FIX_UP);
      push("br3_done", V_DONE);
      issue(3'd3);
      cycles(3 + PF);
      drain("br_s0_c1");

      // ZPIDX with carry: carry ignored, zero page wraps
      co = 1'b1; db_sign = 1'b0;
      push("zp_f1", V_F1);
      push("zp_ea", V_EA_ZP);
      push("zp_done", V_DONE);
      issue(3'd1);
      cycles(3);
      drain("zpidx");

      // Single-step modes
      co = 1'b0;
      push("stack_ea", V_EA_R0);
      push("stack_done", V_DONE);
      issue(3'd4);
      cycles(2);
      drain("stack");
      push("restore_ea", V_EA_PC);
      push("restore_done", V_DONE);
      issue(3'd6);
      cycles(2);
      drain("restore");
      push("mode7_ea", V_EA_NX);
      push("mode7_done", V_DONE);
      issue(3'd7);
      cycles(2);
      drain("mode7");

      // VECTOR with a 2-cycle stall in EA2: hold outputs, done delayed by 2
      push("vec_ea", V_EA_R0);
      push("vec_stall1", V_HOLD_B);
      push("vec_stall2", V_HOLD_B);
      push("vec_ea2", V_EA2);
      push("vec_done", V_DONE);
      issue(3'd5);
      cycles(1);
      rdy = 1'b0;
      cycles(2);
      rdy = 1'b1;
      cycles(2);
      drain("vector_stall");

      // Start while busy is ignored; start on the done cycle is accepted
      co = 1'b0;
      push("busy_f1", V_F1);
      push("busy_f2", V_F2);
      push("busy_ea", V_EA_ABS);
      push("busy_done", V_DONE);
      issue(3'd2);
      cycles(1);
      start = 1'b1;
      mode  = 3'd0;
      cycles(1);
      start = 1'b0;
      cycles(1);
      push("b2b_ea", V_EA_R0);
      push("b2b_done", V_DONE);
      issue(3'd4);
      cycles(2);
      drain("busy_b2b");

      // Asynchronous reset during FETCH2 of ABSIDX
      co = 1'b1;
      push("rst_f1", V_F1);
      push("rst_f2", V_F2);
      issue(3'd2);
      cycles(1);
      #6;
      rst_n = 1'b0;
      #1;
      check("reset_mid_seq", 32'(dut_vec), 32'(V_IDLE));
      drain("reset_mid");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Sequencer usable again after the mid-sequence reset
      push("post_rst_ea", V_EA_NX);
      push("post_rst_done", V_DONE);
      issue(3'd0);
      cycles(2);
      drain("post_reset");

      cycles(3);
      check("final_idle", 32'(dut_vec), 32'(V_IDLE));
      check("final_queue_empty", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule : tb_abl_seq
